ctrl_pipe_chain: RTL and testbench
==================================

// Module: ctrl_pipe_chain
// PURPOSE
//  Parametrised multi-stage pipeline register for decoded control words: ALU/operand
//  selects, load type, writeback select, write enables and branch mode. It carries them
//  from decode towards execute/memory/writeback.
//  Adds a per-stage valid bit, a global stall, per-stage flush (bubble insertion) and
//  saturating bubble/flush performance counters.
//  Instantiated between ID and the later stages; one instance replaces the per-stage
//  hand-written control registers.
// PARAMETERS
//  CW        24    control word width in bits (concatenated control fields)
//  STAGES    1     number of register stages, legal range 1..4
//  NOP_WORD  0     CW-bit word loaded on reset/flush; all write enables are inactive in it
//  CNT_W     16    width of each performance counter
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          reset; asynchronous, active-high
//  ctrl_in      in   CW         control word from decode
//  valid_in     in   1          ctrl_in carries a real instruction
//  stall        in   1          freeze all stages this cycle
//  flush        in   STAGES     flush[k]: load NOP_WORD / valid=0 into stage k
//  cnt_clr      in   1          synchronous clear of both counters
//  ctrl_out     out  CW         stage STAGES-1 control word
//  valid_out    out  1          stage STAGES-1 valid
//  stage_valid  out  STAGES     valid bit of every stage (bit k = stage k)
//  bubble_cnt   out  CNT_W      cycles with valid_out==0 and stall==0, saturating
//  flush_cnt    out  CNT_W      cycles with flush!=0, saturating
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stream):
//    - every stage word = NOP_WORD; every valid = 0.
//    - bubble_cnt = flush_cnt = 0.
//    - Outputs reflect this immediately, no clock edge needed.
//  - Normal (stall=0, flush=0), each edge:
//    - stage0 <= {ctrl_in, valid_in}; stage k <= stage k-1.
//    - Latency ctrl_in -> ctrl_out = STAGES cycles; throughput 1 word/cycle.
//  - stall=1: every stage keeps its word and valid; ctrl_in/valid_in are dropped
//    (the upstream stage must hold them).
//  - flush[k]=1: stage k <= NOP_WORD and valid 0, regardless of stall.
//    - Flush has priority over both stall and shift.
//    - Non-flushed stages follow the stall/shift rule above.
//  - Simultaneous flush[k] and stall:
//    - stage k becomes a bubble; the other stages hold.
//    - No word is duplicated or lost except the flushed one.
//  - Flush of stage k while shifting, stall=0:
//    - stage k+1 still receives the old stage k content this edge.
//    - Only stage k's new content is replaced.
//  - valid_in=0 propagates as a bubble: the word is shifted as presented, with valid 0.
//    Consumers qualify every ctrl_out field with valid_out.
//  - ctrl_out, valid_out and stage_valid are registered outputs; no combinational path
//    from any input.
//  - bubble_cnt: +1 on each edge where valid_out==0 && stall==0 (pre-edge values).
//  - flush_cnt: +1 on each edge where |flush==1.
//  - Both counters saturate at 2^CNT_W-1; they never wrap.
//  - cnt_clr=1: both counters <= 0 on the edge. Clear wins over a same-cycle increment.
//  - STAGES outside 1..4: elaboration error via generate-time check.
// TESTING
//  - Reset mid-stream:
//    - Stimulus: CW=24, STAGES=3; stream 3 valid words, assert rst between edges.
//    - Response: ctrl_out=0, valid_out=0, stage_valid=3'b000 and both counters 0 before
//      the next edge.
//  - Latency:
//    - Stimulus: STAGES=3; ctrl_in=24'hA5A5A5, valid_in=1 at cycle 0, then valid_in=0.
//    - Response: ctrl_out=24'hA5A5A5 with valid_out=1 exactly at cycle 3, valid_out=0
//      at cycle 4.
//  - Stall:
//    - Stimulus: STAGES=2; words 24'h000001, 24'h000002 in flight; stall=1 for 4 cycles.
//    - Response: ctrl_out frozen at 24'h000001 for those 4 cycles; then 24'h000002 the
//      cycle after stall drops; no duplicates.
//  - Flush vs stall:
//    - Stimulus: STAGES=3, all stages valid; stall=1 and flush=3'b010 in the same cycle.
//    - Response: stage_valid=3'b101; stage1 word = NOP_WORD; stages 0 and 2 unchanged;
//      flush_cnt=1.
//  - Counter saturation and clear:
//    - Stimulus: CNT_W=4, valid_in=0, stall=0 for 20 cycles.
//    - Response: bubble_cnt reaches 4'hF and holds.
//    - Stimulus: cnt_clr=1 on a cycle where an increment also occurs.
//    - Response: bubble_cnt=0 after that edge.
//  - Random regression:
//    - Stimulus: 10k cycles of random ctrl_in/valid_in/stall/flush, for STAGES=1..4.
//    - Response: outputs match the cycle-accurate reference queue model on every cycle.

Source files
------------

// File: rtl/ctrl_pipe_chain_if.sv
// Interface bundling the control-word pipeline signals.
//   master: the side that feeds decode words and consumes the delayed words/counters.
//   slave : the pipeline itself.
// Signals:
//   ctrl_in/valid_in  decoded control word and its valid qualifier
//   stall             freeze every stage this cycle
//   flush[k]          turn stage k into a bubble on the next edge
//   cnt_clr           synchronous clear of both performance counters
//   ctrl_out/valid_out last-stage word and valid
//   stage_valid       valid bit of every stage (bit k = stage k)
//   bubble_cnt/flush_cnt saturating performance counters
interface ctrl_pipe_chain_if #(
  parameter int unsigned CW     = 24,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
);
  logic [CW-1:0]     ctrl_in;
  logic              valid_in;
  logic              stall;
  logic [STAGES-1:0] flush;
  logic              cnt_clr;
  logic [CW-1:0]     ctrl_out;
  logic              valid_out;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output ctrl_in, valid_in, stall, flush, cnt_clr,
    input  ctrl_out, valid_out, stage_valid, bubble_cnt, flush_cnt
  );

  modport slave (
    input  ctrl_in, valid_in, stall, flush, cnt_clr,
    output ctrl_out, valid_out, stage_valid, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// Multi-stage pipeline register for decoded control words, with per-stage valid,
// global stall, per-stage flush (bubble insertion) and saturating bubble/flush counters.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  ctrl_pipe_chain_if slave modport (control word in/out, stall, flush, counters)
// The interface instance must use the same CW/STAGES/CNT_W as this module.
module ctrl_pipe_chain #(
  parameter int unsigned    CW       = 24,
  parameter int unsigned    STAGES   = 1,
  parameter logic [CW-1:0]  NOP_WORD = '0,
  parameter int unsigned    CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  ctrl_pipe_chain_if.slave bus
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("ctrl_pipe_chain: STAGES must be in the range 1..4");
  end

  logic [STAGES-1:0][CW-1:0] word_q, word_d;
  logic [STAGES-1:0]         valid_q, valid_d;
  logic [CNT_W-1:0]          bubble_q, bubble_d;
  logic [CNT_W-1:0]          flush_q, flush_d;

  // Per-stage next state: flush beats stall, stall beats shift. The shift source is
  // always the pre-edge content of the previous stage, so flushing stage k still lets
  // stage k+1 take stage k's old word.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0] shift_word;
    logic          shift_valid;

    if (k == 0) begin : g_head
      assign shift_word  = bus.ctrl_in;
      assign shift_valid = bus.valid_in;
    end else begin : g_body
      assign shift_word  = word_q[k-1];
      assign shift_valid = valid_q[k-1];
    end

    assign word_d[k]  = bus.flush[k] ? NOP_WORD : (bus.stall ? word_q[k]  : shift_word);
    assign valid_d[k] = bus.flush[k] ? 1'b0     : (bus.stall ? valid_q[k] : shift_valid);
  end

  // Counters look at pre-edge valid_out; clear wins over a same-cycle increment.
  always_comb begin
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (bus.cnt_clr) begin
      bubble_d = '0;
      flush_d  = '0;
    end else begin
      if (!valid_q[STAGES-1] && !bus.stall && (bubble_q != '1)) begin
        bubble_d = bubble_q + 1'b1;
      end
      if ((|bus.flush) && (flush_q != '1)) begin
        flush_d = flush_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= {STAGES{NOP_WORD}};
      valid_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      word_q   <= word_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.ctrl_out    = word_q[STAGES-1];
  assign bus.valid_out   = valid_q[STAGES-1];
  assign bus.stage_valid = valid_q;
  assign bus.bubble_cnt  = bubble_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: four instances (STAGES=1..4, CW=24, CNT_W=4) share one
// stimulus stream; directed scenarios target one instance, the random run checks all
// four against a reference model through a queue of expected per-cycle outputs.
module tb_ctrl_pipe_chain;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ctrl_in;
  logic        valid_in;
  logic        stall;
  logic [3:0]  flush;
  logic        cnt_clr;

  logic [23:0] obs_co [4];
  logic        obs_vo [4];
  logic [3:0]  obs_sv [4];
  logic [3:0]  obs_bc [4];
  logic [3:0]  obs_fc [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] co;
    logic        vo;
    logic [3:0]  sv;
    logic [3:0]  bc;
    logic [3:0]  fc;
  } exp_t;

  exp_t        exp_q  [$];
  logic [23:0] word_sb[$];

  // Reference model state, indexed [instance][stage]; instance i has i+1 stages.
  logic [23:0] m_w [4][4];
  logic        m_v [4][4];
  logic [3:0]  m_bc[4];
  logic [3:0]  m_fc[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ctrl_pipe_chain_if #(.CW(24), .STAGES(g + 1), .CNT_W(4)) bus ();

    ctrl_pipe_chain #(
      .CW      (24),
      .STAGES  (g + 1),
      .NOP_WORD(24'h000000),
      .CNT_W   (4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.ctrl_in  = ctrl_in;
    assign bus.valid_in = valid_in;
    assign bus.stall    = stall;
    assign bus.flush    = flush[g:0];
    assign bus.cnt_clr  = cnt_clr;
    assign obs_co[g]    = bus.ctrl_out;
    assign obs_vo[g]    = bus.valid_out;
    assign obs_sv[g]    = 4'(bus.stage_valid);
    assign obs_bc[g]    = bus.bubble_cnt;
    assign obs_fc[g]    = bus.flush_cnt;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ctrl_in  = '0;
    valid_in = 1'b0;
    stall    = 1'b0;
    flush    = '0;
    cnt_clr  = 1'b0;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_w[i][k] = '0;
        m_v[i][k] = 1'b0;
      end
      m_bc[i] = '0;
      m_fc[i] = '0;
    end
  endtask

  // Advance the model one edge using the inputs now applied; push expected outputs.
  task automatic model_step;
    for (int i = 0; i < 4; i++) begin
      int          s;
      logic [23:0] ow[4];
      logic        ov[4];
      logic        binc;
      logic        finc;
      exp_t        e;
      s = i + 1;
      for (int k = 0; k < 4; k++) begin
        ow[k] = m_w[i][k];
        ov[k] = m_v[i][k];
      end
      binc = !ov[s-1] && !stall;
      finc = 1'b0;
      for (int k = 0; k < s; k++) begin
        finc = finc | flush[k];
        if (flush[k]) begin
          m_w[i][k] = '0;
          m_v[i][k] = 1'b0;
        end else if (!stall) begin
          m_w[i][k] = (k == 0) ? ctrl_in  : ow[k-1];
          m_v[i][k] = (k == 0) ? valid_in : ov[k-1];
        end
      end
      if (cnt_clr) begin
        m_bc[i] = '0;
        m_fc[i] = '0;
      end else begin
        if (binc && m_bc[i] != 4'hF) m_bc[i] = m_bc[i] + 4'd1;
        if (finc && m_fc[i] != 4'hF) m_fc[i] = m_fc[i] + 4'd1;
      end
      e.co = m_w[i][s-1];
      e.vo = m_v[i][s-1];
      e.sv = '0;
      for (int k = 0; k < s; k++) e.sv[k] = m_v[i][k];
      e.bc = m_bc[i];
      e.fc = m_fc[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({obs_co[i], obs_vo[i], obs_sv[i], obs_bc[i], obs_fc[i]} !== 37'd0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got co=%h vo=%b sv=%b bc=%h fc=%h, expected all 0",
                 i, obs_co[i], obs_vo[i], obs_sv[i], obs_bc[i], obs_fc[i]);
      end
    end
    rst = 1'b0;
    tick();
    // Stream three valid words into the 3-stage instance, then reset between edges.
    for (int n = 1; n <= 3; n++) begin
      ctrl_in  = 24'h000100 + 24'(n);
      valid_in = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if (obs_vo[2] !== 1'b1 || obs_co[2] !== 24'h000101) begin
      errors++;
      $display("FAIL reset_prefill: got vo=%b co=%h, expected vo=1 co=000101",
               obs_vo[2], obs_co[2]);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_co[2] !== 24'h0 || obs_vo[2] !== 1'b0 || obs_sv[2] !== 4'b0000 ||
        obs_bc[2] !== 4'h0 || obs_fc[2] !== 4'h0) begin
      errors++;
      $display("FAIL reset_midstream: got co=%h vo=%b sv=%b bc=%h fc=%h, expected all 0",
               obs_co[2], obs_vo[2], obs_sv[2], obs_bc[2], obs_fc[2]);
    end
    #2;
    rst = 1'b0;
  endtask

  task automatic test_latency;
    int          n;
    logic        found;
    logic [23:0] expw;
    idle_inputs();
    ctrl_in  = 24'hA5A5A5;
    valid_in = 1'b1;
    word_sb.push_back(24'hA5A5A5);
    tick();
    n = 1;
    idle_inputs();
    found = 1'b0;
    while (!found && n < 8) begin
      if (obs_vo[2] === 1'b1) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL latency_timeout: got no valid_out within %0d cycles, expected one at 3", n);
    end else begin
      expw = (word_sb.size() != 0) ? word_sb.pop_front() : 24'hxxxxxx;
      checks++;
      if (n != 3) begin
        errors++;
        $display("FAIL latency_cycle: got valid_out at cycle %0d, expected 3", n);
      end
      checks++;
      if (obs_co[2] !== expw) begin
        errors++;
        $display("FAIL latency_word: got %h, expected %h", obs_co[2], expw);
      end
    end
    tick();
    checks++;
    if (obs_vo[2] !== 1'b0) begin
      errors++;
      $display("FAIL latency_after: got valid_out=%b at cycle 4, expected 0", obs_vo[2]);
    end
  endtask

  task automatic test_stall;
    idle_inputs();
    for (int n = 0; n < 4; n++) tick();
    ctrl_in  = 24'h000001;
    valid_in = 1'b1;
    tick();
    ctrl_in = 24'h000002;
    tick();
    ctrl_in = 24'h000003;
    stall   = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (obs_co[1] !== 24'h000001 || obs_vo[1] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle%0d: got co=%h vo=%b, expected co=000001 vo=1",
                 n, obs_co[1], obs_vo[1]);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (obs_co[1] !== 24'h000002 || obs_vo[1] !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got co=%h vo=%b, expected co=000002 vo=1",
               obs_co[1], obs_vo[1]);
    end
    idle_inputs();
    tick();
    checks++;
    if (obs_co[1] !== 24'h000003 || obs_vo[1] !== 1'b1) begin
      errors++;
      $display("FAIL stall_next: got co=%h vo=%b, expected co=000003 vo=1",
               obs_co[1], obs_vo[1]);
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  task automatic test_flush_stall;
    idle_inputs();
    cnt_clr  = 1'b1;
    ctrl_in  = 24'h000011;
    valid_in = 1'b1;
    tick();
    cnt_clr = 1'b0;
    ctrl_in = 24'h000022;
    tick();
    ctrl_in = 24'h000033;
    tick();
    ctrl_in = 24'h000044;
    stall   = 1'b1;
    flush   = 4'b0010;
    tick();
    checks++;
    if (obs_sv[2] !== 4'b0101) begin
      errors++;
      $display("FAIL flush_stall_sv: got %b, expected 0101", obs_sv[2]);
    end
    checks++;
    if (obs_co[2] !== 24'h000011 || obs_vo[2] !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_out: got co=%h vo=%b, expected co=000011 vo=1",
               obs_co[2], obs_vo[2]);
    end
    checks++;
    if (obs_fc[2] !== 4'h1) begin
      errors++;
      $display("FAIL flush_stall_cnt: got %h, expected 1", obs_fc[2]);
    end
    idle_inputs();
    tick();
    checks++;
    if (obs_co[2] !== 24'h000000 || obs_vo[2] !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall_nop: got co=%h vo=%b, expected co=000000 vo=0",
               obs_co[2], obs_vo[2]);
    end
    tick();
    checks++;
    if (obs_co[2] !== 24'h000033 || obs_vo[2] !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_stage0: got co=%h vo=%b, expected co=000033 vo=1",
               obs_co[2], obs_vo[2]);
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  task automatic test_counters;
    idle_inputs();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    stall   = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (obs_bc[0] !== 4'h0) begin
      errors++;
      $display("FAIL bubble_stalled: got %h, expected 0", obs_bc[0]);
    end
    stall = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    checks++;
    if (obs_bc[0] !== 4'h5) begin
      errors++;
      $display("FAIL bubble_count: got %h, expected 5", obs_bc[0]);
    end
    for (int n = 0; n < 15; n++) tick();
    checks++;
    if (obs_bc[0] !== 4'hF) begin
      errors++;
      $display("FAIL bubble_saturate: got %h, expected f", obs_bc[0]);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (obs_bc[0] !== 4'h0) begin
      errors++;
      $display("FAIL bubble_clear: got %h, expected 0", obs_bc[0]);
    end
    flush = 4'b0001;
    for (int n = 0; n < 20; n++) tick();
    checks++;
    if (obs_fc[0] !== 4'hF) begin
      errors++;
      $display("FAIL flush_saturate: got %h, expected f", obs_fc[0]);
    end
    cnt_clr = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (obs_fc[0] !== 4'h0) begin
      errors++;
      $display("FAIL flush_clear: got %h, expected 0", obs_fc[0]);
    end
  endtask

  task automatic test_random;
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ctrl_in  = 24'($urandom);
      valid_in = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++) flush[b] = ($urandom_range(0, 9) == 0);
      cnt_clr  = ($urandom_range(0, 49) == 0);
      model_step();
      tick();
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        checks++;
        if ({obs_co[i], obs_vo[i], obs_sv[i], obs_bc[i], obs_fc[i]} !==
            {e.co, e.vo, e.sv, e.bc, e.fc}) begin
          errors++;
          $display("FAIL random cyc%0d inst%0d: got co=%h vo=%b sv=%b bc=%h fc=%h, expected co=%h vo=%b sv=%b bc=%h fc=%h",
                   cyc, i, obs_co[i], obs_vo[i], obs_sv[i], obs_bc[i], obs_fc[i],
                   e.co, e.vo, e.sv, e.bc, e.fc);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush_stall();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
